// File: rtl/updown_counter_nb.sv
// Parametrised synchronous up/down counter with modulus, parallel load,
// wrap-or-saturate limits, terminal count, one-cycle wrap pulse and sticky overflow.
module updown_counter_nb #(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     MAX      = {WIDTH{1'b1}},
  parameter bit                   SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             T,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_limit;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_q_next;

  assign w_at_max  = (r_q == MAX);
  assign w_at_zero = (r_q == '0);

  // A limit event is exactly the terminal-count condition; tc exposes it
  // combinationally so it can feed the T of a cascaded counter.
  assign w_limit    = T & ((up & w_at_max) | (~up & w_at_zero));
  assign w_load_val = (D > MAX) ? MAX : D;

  always_comb begin
    w_q_next = r_q;
    if (T) begin
      if (up) begin
        if (w_at_max) w_q_next = SATURATE ? MAX : '0;
        else          w_q_next = r_q + 1'b1;
      end else begin
        if (w_at_zero) w_q_next = SATURATE ? '0 : MAX;
        else           w_q_next = r_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (ld) begin
      r_q    <= w_load_val;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_limit;
      r_ovf  <= r_ovf | w_limit;
    end
  end

  assign Q    = r_q;
  assign tc   = w_limit;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_updown_counter_nb.sv
// Scoreboard bench for updown_counter_nb across four parameter sets:
// 8-bit full range wrap, mod-10 wrap, mod-10 saturate and mod-2 wrap.
module tb_updown_counter_nb;

  logic       clk;
  logic       clr [4];
  logic       T   [4];
  logic       up  [4];
  logic       ld  [4];
  logic [7:0] D   [4];

  logic [7:0] q0;
  logic [3:0] q1, q2;
  logic [1:0] q3;
  logic       tc   [4];
  logic       wrap [4];
  logic       ovf  [4];

  typedef struct {
    string      nm;
    int         k;
    logic [7:0] q;
    logic       w;
    logic       o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  updown_counter_nb #(.WIDTH(8), .MAX(8'd255), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .clr(clr[0]), .T(T[0]), .up(up[0]), .ld(ld[0]), .D(D[0]),
    .Q(q0), .tc(tc[0]), .wrap(wrap[0]), .ovf(ovf[0]));

  updown_counter_nb #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) u_m10w (
    .clk(clk), .clr(clr[1]), .T(T[1]), .up(up[1]), .ld(ld[1]), .D(D[1][3:0]),
    .Q(q1), .tc(tc[1]), .wrap(wrap[1]), .ovf(ovf[1]));

  updown_counter_nb #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) u_m10s (
    .clk(clk), .clr(clr[2]), .T(T[2]), .up(up[2]), .ld(ld[2]), .D(D[2][3:0]),
    .Q(q2), .tc(tc[2]), .wrap(wrap[2]), .ovf(ovf[2]));

  updown_counter_nb #(.WIDTH(2), .MAX(2'd1), .SATURATE(1'b0)) u_m2w (
    .clk(clk), .clr(clr[3]), .T(T[3]), .up(up[3]), .ld(ld[3]), .D(D[3][1:0]),
    .Q(q3), .tc(tc[3]), .wrap(wrap[3]), .ovf(ovf[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] get_q(input int k);
    case (k)
      0:       get_q = q0;
      1:       get_q = {4'b0, q1};
      2:       get_q = {4'b0, q2};
      default: get_q = {6'b0, q3};
    endcase
  endfunction

  // Drive one cycle on DUT k; etc >= 0 also checks tc before the edge.
  task automatic step(input int k, input logic c, input logic l, input logic t,
                      input logic u, input logic [7:0] d, input int etc,
                      input logic [7:0] eq, input logic ew, input logic eo,
                      input string nm);
    exp_t e;
    clr[k] = c; ld[k] = l; T[k] = t; up[k] = u; D[k] = d;
    #1;
    if (etc >= 0) begin
      checks++;
      if (tc[k] !== etc[0]) begin
        errors++;
        $display("FAIL %s dut%0d tc: got %b expected %b", nm, k, tc[k], etc[0]);
      end
    end
    e.nm = nm; e.k = k; e.q = eq; e.w = ew; e.o = eo;
    sb.push_back(e);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (get_q(e.k) !== e.q) begin
        errors++;
        $display("FAIL %s dut%0d Q: got %0d expected %0d", e.nm, e.k, get_q(e.k), e.q);
      end
      checks++;
      if (wrap[e.k] !== e.w) begin
        errors++;
        $display("FAIL %s dut%0d wrap: got %b expected %b", e.nm, e.k, wrap[e.k], e.w);
      end
      checks++;
      if (ovf[e.k] !== e.o) begin
        errors++;
        $display("FAIL %s dut%0d ovf: got %b expected %b", e.nm, e.k, ovf[e.k], e.o);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) step(k, 1, 0, 0, 0, 8'h00, -1, 8'd0, 0, 0, "reset");
    // After reset Q==0, so tc follows T & ~up
    step(0, 0, 0, 1, 0, 8'h00, 1, 8'd255, 1, 1, "reset_down_wrap");
    step(0, 1, 1, 1, 1, 8'h55, 1, 8'd0, 0, 0, "reset_clr_wins");
  endtask

  task automatic test_up_wrap();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] nq;
      nq = 8'((i + 1) % 256);
      step(0, 0, 0, 1, 1, 8'h00, (i == 255) ? 1 : 0, nq,
           (i == 255), (i == 255), "up_wrap");
    end
    step(0, 0, 0, 0, 1, 8'h00, 0, 8'd0, 0, 1, "up_wrap_hold");
  endtask

  task automatic test_down_wrap();
    step(1, 0, 1, 0, 0, 8'd2, -1, 8'd2, 0, 0, "down_load");
    step(1, 0, 0, 1, 0, 8'd0, 0, 8'd1, 0, 0, "down_2to1");
    step(1, 0, 0, 1, 0, 8'd0, 0, 8'd0, 0, 0, "down_1to0");
    step(1, 0, 0, 1, 0, 8'd0, 1, 8'd9, 1, 1, "down_0to9");
    step(1, 0, 0, 1, 0, 8'd0, 0, 8'd8, 0, 1, "down_9to8");
  endtask

  task automatic test_saturate();
    step(2, 0, 1, 0, 1, 8'd8, -1, 8'd8, 0, 0, "sat_load");
    step(2, 0, 0, 1, 1, 8'd0, 0, 8'd9, 0, 0, "sat_8to9");
    step(2, 0, 0, 1, 1, 8'd0, 1, 8'd9, 1, 1, "sat_hold1");
    step(2, 0, 0, 1, 1, 8'd0, 1, 8'd9, 1, 1, "sat_hold2");
    step(2, 0, 0, 0, 1, 8'd0, 0, 8'd9, 0, 1, "sat_idle");
    step(2, 1, 0, 0, 0, 8'd0, -1, 8'd0, 0, 0, "sat_clr");
    step(2, 0, 0, 1, 0, 8'd0, 1, 8'd0, 1, 1, "sat_floor1");
    step(2, 0, 0, 1, 0, 8'd0, 1, 8'd0, 1, 1, "sat_floor2");
  endtask

  task automatic test_load_clamp();
    // DUT1 enters with ovf=1 from the down-wrap test; load must clear it
    step(1, 0, 1, 1, 1, 8'd15, -1, 8'd9, 0, 0, "load_clamp");
    step(1, 0, 1, 1, 1, 8'd9, 1, 8'd9, 0, 0, "load_beats_limit");
    step(1, 1, 1, 1, 1, 8'd5, -1, 8'd0, 0, 0, "clr_beats_load");
    step(3, 0, 1, 0, 0, 8'd3, -1, 8'd1, 0, 0, "load_clamp_m2");
  endtask

  task automatic test_direction();
    step(1, 0, 1, 0, 1, 8'd5, -1, 8'd5, 0, 0, "dir_load");
    step(1, 0, 0, 1, 1, 8'd0, 0, 8'd6, 0, 0, "dir_up1");
    step(1, 0, 0, 1, 1, 8'd0, 0, 8'd7, 0, 0, "dir_up2");
    step(1, 0, 0, 1, 0, 8'd0, 0, 8'd6, 0, 0, "dir_dn1");
    step(1, 0, 0, 1, 0, 8'd0, 0, 8'd5, 0, 0, "dir_dn2");
    step(1, 0, 0, 1, 0, 8'd0, 0, 8'd4, 0, 0, "dir_dn3");
    step(1, 0, 0, 0, 0, 8'd0, 0, 8'd4, 0, 0, "dir_hold1");
    step(1, 0, 0, 0, 1, 8'd0, 0, 8'd4, 0, 0, "dir_hold2");
  endtask

  task automatic test_mid_reset();
    step(1, 1, 0, 0, 0, 8'd0, -1, 8'd0, 0, 0, "mid_clr0");
    step(1, 0, 0, 1, 0, 8'd0, 1, 8'd9, 1, 1, "mid_wrap");
    for (int i = 8; i >= 3; i--)
      step(1, 0, 0, 1, 0, 8'd0, 0, 8'(i), 0, 1, "mid_down");
    step(1, 1, 0, 1, 1, 8'd0, -1, 8'd0, 0, 0, "mid_clr");
    step(1, 0, 0, 1, 1, 8'd0, 0, 8'd1, 0, 0, "mid_resume");
  endtask

  task automatic test_back_to_back();
    step(3, 1, 0, 0, 0, 8'd0, -1, 8'd0, 0, 0, "b2b_clr");
    step(3, 0, 0, 1, 1, 8'd0, 0, 8'd1, 0, 0, "b2b_up1");
    step(3, 0, 0, 1, 1, 8'd0, 1, 8'd0, 1, 1, "b2b_up_wrap");
    step(3, 0, 0, 1, 0, 8'd0, 1, 8'd1, 1, 1, "b2b_dn_wrap");
    step(3, 0, 0, 1, 1, 8'd0, 1, 8'd0, 1, 1, "b2b_up_wrap2");
    step(3, 0, 0, 1, 0, 8'd0, 1, 8'd1, 1, 1, "b2b_dn_wrap2");
    step(3, 0, 0, 1, 0, 8'd0, 0, 8'd0, 0, 1, "b2b_dn");
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      clr[k] = 1'b1; ld[k] = 1'b0; T[k] = 1'b0; up[k] = 1'b0; D[k] = 8'h00;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_direction();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
